// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipelined N-input mux and its skid buffer.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int unsigned DEF_WIDTH = 32;

  // Select width for n inputs; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    if (n < 2) return 32'd1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry skid buffer with valid/ready handshake and flush.
// in_ready is a flop, so there is no combinational path from out_ready to in_ready.
module skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_pl,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [DW-1:0] out_pl,
  output logic          out_valid,
  input  logic          out_ready
);

  occ_t          state, state_nxt;
  logic [DW-1:0] head, skid, head_nxt, skid_nxt;
  logic          ready_q, valid_q;
  logic          accept, drain;

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_pl    = head;
  assign accept    = in_valid & ready_q;
  assign drain     = valid_q & out_ready;

  // State and datapath registers; handshake flags follow the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      head    <= head_nxt;
      skid    <= skid_nxt;
      ready_q <= (state_nxt != TWO);
      valid_q <= (state_nxt != EMPTY);
    end
  end

  // Occupancy transitions; flush overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !drain)      state_nxt = TWO;
        else if (drain && !accept) state_nxt = EMPTY;
      end
      TWO:     if (drain) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Entry movement: fill the free slot, or promote the skid entry on drain.
  always_comb begin
    head_nxt = head;
    skid_nxt = skid;
    case (state)
      EMPTY: if (accept) head_nxt = in_pl;
      ONE: begin
        if (accept) begin
          if (drain) head_nxt = in_pl;
          else       skid_nxt = in_pl;
        end
      end
      TWO:     if (drain) head_nxt = skid;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_mux_n.sv
// N-input registered mux feeding a skid buffer; one-cycle latency.
// Define PIPE_MUX_SEL_CHECK_EN to zero out-of-range selections and flag them on err.
module pipe_mux_n
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned SEL_W = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef PIPE_MUX_SEL_CHECK_EN
  ,
  output logic                  err
`endif
);

`ifdef PIPE_MUX_SEL_CHECK_EN
  localparam int unsigned PW = WIDTH + SEL_W + 1;
  logic sel_err;
`else
  localparam int unsigned PW = WIDTH + SEL_W;
`endif

  logic [WIDTH-1:0] sel_data;
  logic [PW-1:0]    in_pl, out_pl;

  // Input selection; unmatched selects fall back to input 0.
  always_comb begin
    sel_data = in_data[WIDTH-1:0];
    for (int unsigned k = 1; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
`ifdef PIPE_MUX_SEL_CHECK_EN
    sel_err = 1'b0;
    if (32'(sel) >= N_IN) begin
      sel_data = '0;
      sel_err  = 1'b1;
    end
`endif
  end

`ifdef PIPE_MUX_SEL_CHECK_EN
  assign in_pl = {sel_err, sel, sel_data};
  assign err   = out_pl[PW-1];
`else
  assign in_pl = {sel, sel_data};
`endif
  assign out_data = out_pl[WIDTH-1:0];
  assign out_sel  = out_pl[WIDTH +: SEL_W];

  skid_buf #(.DW(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pl     (in_pl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_pl    (out_pl),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed and randomised handshake bench for pipe_mux_n (N_IN=4) plus an N_IN=3 instance.
module tb_pipe_mux_n;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid, in_ready, flush;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid, out_ready;

  logic [95:0]  in_data3;
  logic [1:0]   sel3;
  logic         in_valid3, in_ready3, flush3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_valid3, out_ready3;
`ifdef PIPE_MUX_SEL_CHECK_EN
  logic         err, err3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipe_mux_n #(.WIDTH(32), .N_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef PIPE_MUX_SEL_CHECK_EN
    , .err(err)
`endif
  );

  pipe_mux_n #(.WIDTH(32), .N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3)
`ifdef PIPE_MUX_SEL_CHECK_EN
    , .err(err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int s);
    return 32'(32'h11 * (s + 1));
  endfunction

  initial begin
    int q[$];
    bit acc, drn;

    rst_n     = 1'b0;
    in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    sel       = 2'd0;
    in_valid  = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_data3  = {32'h33, 32'h22, 32'h11};
    sel3      = 2'd0;
    in_valid3 = 1'b0;
    flush3    = 1'b0;
    out_ready3 = 1'b1;

    // Reset held for three cycles with in_valid high
    tick; tick; tick;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_sel",   64'(out_sel),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick;
    check("post_rst_in_ready",  64'(in_ready),  64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Streaming, one transfer per cycle with no bubbles
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      sel      = 2'(i);
      tick;
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data",  64'(out_data),  64'(exp_data(i)));
      check("stream_sel",   64'(out_sel),   64'(i));
      check("stream_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    tick;
    check("stream_idle_valid", 64'(out_valid), 64'd0);

    // Backpressure: two accepted, third refused, then ordered drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd0;
    tick;
    check("bp1_ready", 64'(in_ready), 64'd1);
    check("bp1_data",  64'(out_data), 64'h11);
    sel = 2'd1;
    tick;
    check("bp2_ready", 64'(in_ready), 64'd0);
    check("bp2_data",  64'(out_data), 64'h11);
    sel = 2'd2;
    tick;
    check("bp3_ready",  64'(in_ready),  64'd0);
    check("bp3_stable", 64'(out_data),  64'h11);
    check("bp3_valid",  64'(out_valid), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    check("bp_drain1_data",  64'(out_data),  64'h22);
    check("bp_drain1_sel",   64'(out_sel),   64'd1);
    check("bp_drain1_ready", 64'(in_ready),  64'd1);
    tick;
    check("bp_drain2_valid", 64'(out_valid), 64'd0);

    // Flush race with the buffer full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd2;
    tick;
    sel = 2'd3;
    tick;
    check("fl_full_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    sel   = 2'd1;
    tick;
    check("fl_full_valid", 64'(out_valid), 64'd0);
    check("fl_full_ready_after", 64'(in_ready), 64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    check("fl_full_nothing", 64'(out_valid), 64'd0);

    // Flush beats a same-cycle accept into a one-entry buffer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd0;
    tick;
    check("fl_one_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    sel   = 2'd1;
    tick;
    check("fl_one_valid_after", 64'(out_valid), 64'd0);
    check("fl_one_ready_after", 64'(in_ready),  64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    check("fl_one_nothing", 64'(out_valid), 64'd0);

    // Random handshake against an occupancy/ordering model
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      check("rnd_in_ready",  64'(in_ready),  64'(q.size() < 2));
      check("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check("rnd_out_data", 64'(out_data), 64'(exp_data(q[0])));
        check("rnd_out_sel",  64'(out_sel),  64'(q[0]));
      end
      tick;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(int'(sel));
    end
    in_valid = 1'b0;

    // Out-of-range select on a three-input instance
    in_valid3 = 1'b1;
    sel3      = 2'd3;
    tick;
    check("n3_oor_valid", 64'(out_valid3), 64'd1);
    check("n3_oor_sel",   64'(out_sel3),   64'd3);
`ifdef PIPE_MUX_SEL_CHECK_EN
    check("n3_oor_data",  64'(out_data3),  64'd0);
    check("n3_oor_err",   64'(err3),       64'd1);
`else
    check("n3_oor_data",  64'(out_data3),  64'h11);
`endif
    sel3 = 2'd2;
    tick;
    check("n3_in_range_data", 64'(out_data3), 64'h33);
`ifdef PIPE_MUX_SEL_CHECK_EN
    check("n3_in_range_err",  64'(err3),      64'd0);
`endif
    in_valid3 = 1'b0;
    tick;
    check("n3_idle_valid", 64'(out_valid3), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
